// File: rtl/eth_pkg.sv
// Shared definitions for the 100 Mb/s Ethernet transmit path: framer states,
// MII framing constants and the nibble-wide CRC-32 step.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam int          PRE_NIBS     = 15;
    localparam int          FCS_NIBS     = 8;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;

    // MSB-first CRC register; data bits enter in wire order (bit 0 first).
    function automatic logic [31:0] crc32_nib(input logic [31:0] crc, input logic [3:0] data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 4; i++) begin
            r = {r[30:0], 1'b0} ^ (((r[31] ^ data[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d4.sv
// Ethernet CRC-32 register advanced one MII nibble per enabled clock.
module crc32_d4
    import eth_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        crc_clr,
    input  logic        crc_en,
    input  logic [3:0]  data,
    output logic [31:0] crc_data,
    output logic [31:0] crc_next
);

    logic [31:0] crc_reg;

    assign crc_next = crc32_nib(crc_reg, data);
    assign crc_data = crc_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_reg <= 32'hFFFF_FFFF;
        end else if (crc_clr) begin
            crc_reg <= 32'hFFFF_FFFF;
        end else if (crc_en) begin
            crc_reg <= crc_next;
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD insertion, zero padding, FCS append and
// inter-frame gap, one nibble per sys_clk.
module mii_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_BYTES = 60,
    parameter int IFG_NIB   = 24
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_en,
    output logic [3:0] tx_data,
    output logic       busy,
    output logic       underrun
);

    // Start-up spends two low cycles in IDLE, so IFG is shortened by two to
    // keep the wire gap at IFG_NIB for back-to-back frames.
    localparam int          IFG_HOLD = (IFG_NIB > 2) ? IFG_NIB - 2 : 1;
    localparam logic [15:0] PRE_LAST = 16'(PRE_NIBS - 1);
    localparam logic [15:0] FCS_LAST = 16'(FCS_NIBS - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_HOLD - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_BYTES);

    tx_state_t   state_reg;
    logic [15:0] nib_cnt_reg;
    logic [15:0] byte_cnt_reg;
    logic [7:0]  byte_reg;
    logic        last_reg;
    logic        phase_reg;
    logic        poison_reg;
    logic        start_req_reg;
    logic        s_ready_reg;
    logic        busy_reg;
    logic        underrun_reg;
    logic        tx_en_reg;
    logic [3:0]  tx_data_reg;

    logic [3:0]  nib_mux;
    logic        en_mux;
    logic [4:0]  fcs_msb;
    logic [15:0] byte_cnt_inc;
    logic        need_pad;
    logic [15:0] pad_diff_unused;
    logic        crc_clr;
    logic        crc_en;
    logic [31:0] crc_data;
    logic [31:0] crc_next_unused;

    assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;
    // Borrow of (count - MIN) is set exactly when more padding is required.
    assign {need_pad, pad_diff_unused} = {1'b0, byte_cnt_inc} - {1'b0, MIN_CNT};
    assign fcs_msb = 5'd31 - {nib_cnt_reg[2:0], 2'b00};

    always_comb begin
        nib_mux = 4'h0;
        en_mux  = 1'b0;
        case (state_reg)
            ST_PRE:  begin nib_mux = PREAMBLE_NIB; en_mux = 1'b1; end
            ST_SFD:  begin nib_mux = SFD_NIB;      en_mux = 1'b1; end
            ST_DATA: begin
                nib_mux = phase_reg ? byte_reg[7:4] : byte_reg[3:0];
                en_mux  = 1'b1;
            end
            ST_PAD:  begin nib_mux = 4'h0;         en_mux = 1'b1; end
            ST_FCS:  begin
                nib_mux = {crc_data[fcs_msb - 5'd3], crc_data[fcs_msb - 5'd2],
                           crc_data[fcs_msb - 5'd1], crc_data[fcs_msb]} ^ {4{~poison_reg}};
                en_mux  = 1'b1;
            end
            default: begin nib_mux = 4'h0;         en_mux = 1'b0; end
        endcase
    end

    assign crc_clr = (state_reg == ST_IDLE) || (state_reg == ST_PRE) || (state_reg == ST_SFD);
    assign crc_en  = (state_reg == ST_DATA) || (state_reg == ST_PAD);

    crc32_d4 u_crc (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .crc_clr   (crc_clr),
        .crc_en    (crc_en),
        .data      (nib_mux),
        .crc_data  (crc_data),
        .crc_next  (crc_next_unused)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= ST_IDLE;
            nib_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            byte_reg      <= '0;
            last_reg      <= 1'b0;
            phase_reg     <= 1'b0;
            poison_reg    <= 1'b0;
            start_req_reg <= 1'b0;
            s_ready_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
            tx_en_reg     <= 1'b0;
            tx_data_reg   <= 4'h0;
        end else begin
            underrun_reg <= 1'b0;
            tx_en_reg    <= en_mux;
            tx_data_reg  <= nib_mux;
            case (state_reg)
                ST_IDLE: begin
                    if (start_req_reg) begin
                        state_reg     <= ST_PRE;
                        start_req_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        nib_cnt_reg   <= '0;
                        byte_cnt_reg  <= '0;
                        poison_reg    <= 1'b0;
                        phase_reg     <= 1'b0;
                        last_reg      <= 1'b0;
                    end else if (s_valid) begin
                        start_req_reg <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (nib_cnt_reg == PRE_LAST) begin
                        state_reg   <= ST_SFD;
                        s_ready_reg <= 1'b1;
                        nib_cnt_reg <= '0;
                    end else begin
                        nib_cnt_reg <= nib_cnt_reg + 16'd1;
                    end
                end
                ST_SFD: begin
                    s_ready_reg <= 1'b0;
                    if (s_valid) begin
                        byte_reg  <= s_data;
                        last_reg  <= s_last;
                        phase_reg <= 1'b0;
                        state_reg <= ST_DATA;
                    end else begin
                        underrun_reg <= 1'b1;
                        poison_reg   <= 1'b1;
                        nib_cnt_reg  <= '0;
                        state_reg    <= ST_FCS;
                    end
                end
                ST_DATA: begin
                    if (!phase_reg) begin
                        phase_reg   <= 1'b1;
                        s_ready_reg <= ~last_reg;
                    end else begin
                        phase_reg    <= 1'b0;
                        s_ready_reg  <= 1'b0;
                        byte_cnt_reg <= byte_cnt_inc;
                        if (last_reg) begin
                            if (need_pad) begin
                                state_reg <= ST_PAD;
                            end else begin
                                nib_cnt_reg <= '0;
                                state_reg   <= ST_FCS;
                            end
                        end else if (s_valid) begin
                            byte_reg <= s_data;
                            last_reg <= s_last;
                        end else begin
                            underrun_reg <= 1'b1;
                            poison_reg   <= 1'b1;
                            nib_cnt_reg  <= '0;
                            state_reg    <= ST_FCS;
                        end
                    end
                end
                ST_PAD: begin
                    phase_reg <= ~phase_reg;
                    if (phase_reg) begin
                        byte_cnt_reg <= byte_cnt_inc;
                        if (!need_pad) begin
                            nib_cnt_reg <= '0;
                            state_reg   <= ST_FCS;
                        end
                    end
                end
                ST_FCS: begin
                    if (nib_cnt_reg == FCS_LAST) begin
                        nib_cnt_reg <= '0;
                        state_reg   <= ST_IFG;
                    end else begin
                        nib_cnt_reg <= nib_cnt_reg + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (nib_cnt_reg == IFG_LAST) begin
                        nib_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        nib_cnt_reg <= nib_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = s_ready_reg;
    assign busy     = busy_reg;
    assign underrun = underrun_reg;
    assign tx_en    = tx_en_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: one padding instance (default MIN_BYTES)
// and one unpadded instance, driven by a shared byte source selected by sel.
module tb_mii_tx_framer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       sel;

    logic       s_valid0, s_ready0, tx_en0, busy0, und0;
    logic       s_valid1, s_ready1, tx_en1, busy1, und1;
    logic [3:0] tx_data0, tx_data1;
    logic       s_ready_m, tx_en_m, busy_m, und_m;
    logic [3:0] tx_data_m;

    always #5 sys_clk = ~sys_clk;

    assign s_valid0  = s_valid & ~sel;
    assign s_valid1  = s_valid & sel;
    assign s_ready_m = sel ? s_ready1 : s_ready0;
    assign tx_en_m   = sel ? tx_en1   : tx_en0;
    assign tx_data_m = sel ? tx_data1 : tx_data0;
    assign busy_m    = sel ? busy1    : busy0;
    assign und_m     = sel ? und1     : und0;

    mii_tx_framer dut_pad (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s_data(s_data), .s_valid(s_valid0), .s_last(s_last), .s_ready(s_ready0),
        .tx_en(tx_en0), .tx_data(tx_data0), .busy(busy0), .underrun(und0)
    );

    mii_tx_framer #(.MIN_BYTES(0), .IFG_NIB(24)) dut_raw (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s_data(s_data), .s_valid(s_valid1), .s_last(s_last), .s_ready(s_ready1),
        .tx_en(tx_en1), .tx_data(tx_data1), .busy(busy1), .underrun(und1)
    );

    int tests = 0;
    int fails = 0;

    logic [8:0] src_q[$];
    logic [3:0] nib_log[$];
    logic [7:0] cb[$];
    int frame_start[$];
    int frame_len[$];
    int gap_before[$];
    int acc_cnt = 0;
    int stall_at = -1;
    int und_cnt = 0;
    int ready_viol = 0;
    int cur_len = 0;
    int low_run = 0;
    bit prev_en = 1'b0;
    bit prev_ready = 1'b0;
    bit after_last = 1'b0;

    // Monitor first, then byte source; both act on the falling edge.
    always @(negedge sys_clk) begin
        if (und_m) und_cnt++;
        if (s_ready_m && (prev_ready || after_last)) ready_viol++;
        prev_ready = s_ready_m;
        if (tx_en_m) begin
            if (!prev_en) begin
                frame_start.push_back(nib_log.size());
                gap_before.push_back(low_run);
                after_last = 1'b0;
            end
            nib_log.push_back(tx_data_m);
            cur_len++;
        end else begin
            if (prev_en) begin
                frame_len.push_back(cur_len);
                cur_len = 0;
                low_run = 0;
            end
            low_run++;
        end
        prev_en = tx_en_m;

        if (!sys_rst_n) begin
            s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; after_last = 1'b0;
        end else if (src_q.size() > 0 && acc_cnt != stall_at) begin
            s_valid = 1'b1;
            s_data  = src_q[0][7:0];
            s_last  = src_q[0][8];
            if (s_ready_m) begin
                if (src_q[0][8]) after_last = 1'b1;
                void'(src_q.pop_front());
                acc_cnt++;
            end
        end else begin
            s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input int n, input int mult, input int add);
        for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), 8'((i * mult + add) & 255)});
    endtask

    task automatic fill_cb(input int n, input int mult, input int add);
        cb.delete();
        for (int i = 0; i < n; i++) cb.push_back(8'((i * mult + add) & 255));
    endtask

    // Reference CRC-32 in the reflected form, result already complemented.
    function automatic logic [31:0] crc_of();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (cb[i]) begin
            c = c ^ {24'h0, cb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] fcs_word(input int fi);
        logic [31:0] w;
        int e;
        w = 32'h0;
        e = frame_start[fi] + frame_len[fi] - 8;
        for (int k = 0; k < 8; k++) w = w | (32'(nib_log[e + k]) << (4 * k));
        return w;
    endfunction

    // Receiver model: full preamble, SFD, whole bytes and a matching FCS.
    function automatic bit frame_ok(input int fi);
        int st, ln, n;
        st = frame_start[fi];
        ln = frame_len[fi];
        if (ln < 24 || (ln % 2) != 0) return 1'b0;
        for (int j = 0; j < 15; j++) if (nib_log[st + j] != 4'h5) return 1'b0;
        if (nib_log[st + 15] != 4'hD) return 1'b0;
        n = (ln - 24) / 2;
        cb.delete();
        for (int b = 0; b < n; b++) cb.push_back({nib_log[st + 17 + 2 * b], nib_log[st + 16 + 2 * b]});
        return fcs_word(fi) == crc_of();
    endfunction

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench stopped on timeout");
    endtask

    task automatic wait_frames(input int n);
        int cyc;
        cyc = 0;
        while (frame_len.size() < n && cyc < 3000) begin
            @(negedge sys_clk);
            cyc++;
        end
        tests++;
        assert (frame_len.size() >= n) else begin
            fails++;
            $error("FAIL frame_timeout: observed %0d frames expected %0d", frame_len.size(), n);
            finish_now();
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((busy_m || tx_en_m) && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        tests++;
        assert (!busy_m && !tx_en_m) else begin
            fails++;
            $error("FAIL idle_timeout: observed busy %0b expected 0", busy_m);
            finish_now();
        end
        repeat (2) @(negedge sys_clk);
    endtask

    logic [3:0] kv_data[18] = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5, 4'h3,
                                4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3};

    initial begin
        int st, zeros, u0, cyc;
        logic [31:0] exp_w;
        sel = 1'b1;
        sys_rst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_outs_pad", {27'h0, tx_en0, tx_data0, s_ready0, busy0, und0}, 32'h0);
        check("reset_outs_raw", {27'h0, tx_en1, tx_data1, s_ready1, busy1, und1}, 32'h0);
        sys_rst_n = 1'b1;

        // Known vector "123456789" with padding disabled, plus start latency.
        @(posedge sys_clk); #2;
        push_bytes(9, 1, 'h31);
        @(negedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("start_e0_tx_en", 32'(tx_en_m), 32'h0);
        @(negedge sys_clk);
        check("start_e1_tx_en", 32'(tx_en_m), 32'h0);
        check("start_e1_busy", 32'(busy_m), 32'h1);
        @(negedge sys_clk);
        check("start_e2_tx_en", 32'(tx_en_m), 32'h1);
        check("start_e2_nib", 32'(tx_data_m), 32'h5);
        wait_frames(1);
        st = frame_start[0];
        check("kv_len", 32'(frame_len[0]), 32'd42);
        zeros = 0;
        for (int j = 0; j < 15; j++) if (nib_log[st + j] == 4'h5) zeros++;
        check("kv_preamble", 32'(zeros), 32'd15);
        check("kv_sfd", 32'(nib_log[st + 15]), 32'hD);
        for (int j = 0; j < 18; j++) check($sformatf("kv_data%0d", j), 32'(nib_log[st + 16 + j]), 32'(kv_data[j]));
        check("kv_fcs", fcs_word(0), 32'hCBF4_3926);
        check("kv_frame_ok", 32'(frame_ok(0)), 32'h1);
        wait_idle();

        // Single byte padded to 60.
        sel = 1'b0;
        push_bytes(1, 0, 'hAB);
        wait_frames(2);
        st = frame_start[1];
        check("pad_len", 32'(frame_len[1]), 32'd144);
        check("pad_nib_lo", 32'(nib_log[st + 16]), 32'hB);
        check("pad_nib_hi", 32'(nib_log[st + 17]), 32'hA);
        zeros = 0;
        for (int j = 18; j < 136; j++) if (nib_log[st + j] == 4'h0) zeros++;
        check("pad_zero_nibs", 32'(zeros), 32'd118);
        cb.delete();
        cb.push_back(8'hAB);
        for (int j = 0; j < 59; j++) cb.push_back(8'h00);
        exp_w = crc_of();
        check("pad_fcs", fcs_word(1), exp_w);
        check("pad_frame_ok", 32'(frame_ok(1)), 32'h1);
        wait_idle();

        // Two 64-byte frames with s_valid held through FCS and IFG.
        push_bytes(64, 7, 3);
        push_bytes(64, 13, 5);
        wait_frames(4);
        check("b2b_len0", 32'(frame_len[2]), 32'd152);
        check("b2b_len1", 32'(frame_len[3]), 32'd152);
        check("b2b_gap", 32'(gap_before[3]), 32'd24);
        fill_cb(64, 7, 3);
        exp_w = crc_of();
        check("b2b_fcs0", fcs_word(2), exp_w);
        fill_cb(64, 13, 5);
        exp_w = crc_of();
        check("b2b_fcs1", fcs_word(3), exp_w);
        check("b2b_ok0", 32'(frame_ok(2)), 32'h1);
        check("b2b_ok1", 32'(frame_ok(3)), 32'h1);
        wait_idle();

        // Underrun: source stalls after 10 of 64 bytes.
        u0 = und_cnt;
        stall_at = acc_cnt + 10;
        push_bytes(64, 3, 1);
        wait_frames(5);
        check("und_pulses", 32'(und_cnt - u0), 32'd1);
        check("und_len", 32'(frame_len[4]), 32'd44);
        fill_cb(10, 3, 1);
        exp_w = ~crc_of();
        check("und_fcs_raw", fcs_word(4), exp_w);
        check("und_rejected", 32'(frame_ok(4)), 32'h0);
        src_q.delete();
        stall_at = -1;
        check("ready_protocol_a", 32'(ready_viol), 32'd0);
        wait_idle();

        // Asynchronous reset in the middle of DATA.
        push_bytes(64, 5, 9);
        cyc = 0;
        while (frame_start.size() < 6 && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("rst_frame_started", 32'(frame_start.size()), 32'd6);
        repeat (40) @(negedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        check("rst_tx_en_async", 32'(tx_en0), 32'h0);
        check("rst_outs_async", {27'h0, tx_en0, tx_data0, s_ready0, busy0, und0}, 32'h0);
        src_q.delete();
        u0 = und_cnt;
        repeat (3) @(negedge sys_clk);
        check("rst_outs_held", {27'h0, tx_en0, tx_data0, s_ready0, busy0, und0}, 32'h0);
        sys_rst_n = 1'b1;
        push_bytes(20, 11, 2);
        wait_frames(7);
        check("post_rst_len", 32'(frame_len[6]), 32'd144);
        check("post_rst_ok", 32'(frame_ok(6)), 32'h1);
        check("post_rst_no_underrun", 32'(und_cnt - u0), 32'd0);
        check("ready_protocol_b", 32'(ready_viol), 32'd0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
